// File: rtl/mult_seq_pkg.sv
// Shared types and sizing helpers for the sequential radix-4 multiplier.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Sizing for the default 8-bit build; parameterised users call the helpers.
    localparam int WIDTH_DEF  = 8;
    localparam int NUM_DIGITS = WIDTH_DEF / 2;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int ACC_W      = 2 * WIDTH_DEF;

    // Number of radix-4 digits in a WIDTH-bit multiplier.
    function automatic int num_digits(input int width);
        return width / 2;
    endfunction

    // Digit index width, never below one bit so a 2-bit build still has a counter.
    function automatic int idx_width(input int width);
        return ((width / 2) > 1) ? $clog2(width / 2) : 1;
    endfunction

    // Accumulator width holding the exact unsigned product.
    function automatic int acc_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_radix4_pp.sv
// Radix-4 partial product: multiplies B by one unsigned 2-bit digit of A.
module radix4_pp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       digit,
    output logic [WIDTH+1:0] pp
);

    // Select 0, B, 2B or 3B from the digit value.
    always_comb begin
        pp = '0;
        case (digit)
            2'b00:   pp = '0;
            2'b01:   pp = {2'b00, b};
            2'b10:   pp = {1'b0, b, 1'b0};
            2'b11:   pp = {2'b00, b} + {1'b0, b, 1'b0};
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential radix-4 multiplier: one partial product per cycle, valid/ready on
// both sides, zero-operand shortcut and optional early termination.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PO_WIDTH   = 20,
    parameter int EARLY_TERM = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PO_WIDTH-1:0] PO,
    output logic                busy
);

    localparam int ND = num_digits(WIDTH);
    localparam int IW = idx_width(WIDTH);
    localparam int AW = acc_width(WIDTH);

    state_e             state_r, state_nxt_s;
    logic [WIDTH-1:0]   a_r, a_nxt_s;
    logic [WIDTH-1:0]   b_r, b_nxt_s;
    logic [AW-1:0]      acc_r, acc_nxt_s;
    logic [IW-1:0]      idx_r, idx_nxt_s;
    logic [PO_WIDTH-1:0] po_r;
    logic               po_load_s;
    logic               out_valid_r;
    logic               in_ready_r;
    logic               busy_r;

    logic [1:0]         digit_s;
    logic [WIDTH+1:0]   pp_s;
    logic [AW-1:0]      pp_ext_s;
    logic [IW+1:0]      rem_sh_s;
    logic               last_s;

    assign digit_s  = a_r[{idx_r, 1'b0} +: 2];
    assign pp_ext_s = AW'(pp_s);
    // Shift that discards the digits already consumed including the current one.
    assign rem_sh_s = {1'b0, idx_r, 1'b0} + (IW + 2)'(2);
    assign last_s   = (idx_r == IW'(ND - 1)) ||
                      ((EARLY_TERM != 0) && ((a_r >> rem_sh_s) == '0));

    radix4_pp #(
        .WIDTH (WIDTH)
    ) u_pp (
        .b     (b_r),
        .digit (digit_s),
        .pp    (pp_s)
    );

    // Next-state, operand capture and accumulation decisions.
    always_comb begin
        state_nxt_s = state_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        acc_nxt_s   = acc_r;
        idx_nxt_s   = idx_r;
        po_load_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    a_nxt_s   = A;
                    b_nxt_s   = B;
                    acc_nxt_s = '0;
                    idx_nxt_s = '0;
                    if ((A == '0) || (B == '0)) begin
                        state_nxt_s = DONE;
                        po_load_s   = 1'b1;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                acc_nxt_s = acc_r + (pp_ext_s << {idx_r, 1'b0});
                idx_nxt_s = idx_r + IW'(1);
                if (last_s) begin
                    state_nxt_s = DONE;
                    po_load_s   = 1'b1;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    // A zero-shortcut entry into DONE presents out_valid one cycle later, so
    // every product spends at least one edge between accept and delivery.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            idx_r       <= '0;
            po_r        <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            a_r         <= a_nxt_s;
            b_r         <= b_nxt_s;
            acc_r       <= acc_nxt_s;
            idx_r       <= idx_nxt_s;
            if (po_load_s) begin
                po_r <= PO_WIDTH'(acc_nxt_s);
            end else begin
                po_r <= po_r;
            end
            out_valid_r <= (state_nxt_s == DONE) && (state_r != IDLE);
            in_ready_r  <= (state_nxt_s == IDLE);
            busy_r      <= (state_nxt_s == CALC);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign PO        = po_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed scenarios plus randomized
// regression on both EARLY_TERM builds against an arithmetic reference.
module tb_mult_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        sel;   // 1: EARLY_TERM=1 instance, 0: EARLY_TERM=0 instance

    logic        in_ready1, out_valid1, busy1;
    logic        in_ready0, out_valid0, busy0;
    logic [19:0] po1, po0;

    logic        in_ready_m, out_valid_m, busy_m;
    logic [19:0] po_m;

    int checks;
    int errors;

    mult_seq_ctrl #(.WIDTH(8), .PO_WIDTH(20), .EARLY_TERM(1)) dut_et1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & sel),
        .in_ready  (in_ready1),
        .A         (A),
        .B         (B),
        .out_valid (out_valid1),
        .out_ready (out_ready & sel),
        .PO        (po1),
        .busy      (busy1)
    );

    mult_seq_ctrl #(.WIDTH(8), .PO_WIDTH(20), .EARLY_TERM(0)) dut_et0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & ~sel),
        .in_ready  (in_ready0),
        .A         (A),
        .B         (B),
        .out_valid (out_valid0),
        .out_ready (out_ready & ~sel),
        .PO        (po0),
        .busy      (busy0)
    );

    assign in_ready_m  = sel ? in_ready1  : in_ready0;
    assign out_valid_m = sel ? out_valid1 : out_valid0;
    assign busy_m      = sel ? busy1      : busy0;
    assign po_m        = sel ? po1        : po0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference latency in edges after the accept edge.
    function automatic int ref_latency(input logic [7:0] a, input logic [7:0] b, input bit et);
        if (a == 8'd0 || b == 8'd0) return 1;
        if (!et) return 4;
        for (int k = 3; k >= 0; k--) begin
            if (((int'(a) >> (2 * k)) % 4) != 0) return k + 1;
        end
        return 1;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Submit one operand pair and wait for out_valid; out_ready is left to the caller.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int busy_n, output logic [19:0] po_v);
        int w;
        w = 0;
        while (!in_ready_m && w < 50) begin
            cycle();
            w++;
        end
        checks++;
        if (in_ready_m !== 1'b1) begin
            errors++;
            $display("FAIL run_op_idle: in_ready=%b required 1", in_ready_m);
        end
        A = a; B = b; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        A = 8'($urandom); B = 8'($urandom);
        lat = 0; busy_n = 0;
        while (!out_valid_m && lat < 40) begin
            busy_n += int'(busy_m);
            cycle();
            lat++;
        end
        po_v = po_m;
    endtask

    task automatic deliver();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = 8'd0; B = 8'd0; sel = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || po1 !== 20'd0) begin
            errors++;
            $display("FAIL reset_et1: ov=%b busy=%b po=%h required 0 0 00000", out_valid1, busy1, po1);
        end
        checks++;
        if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || po0 !== 20'd0) begin
            errors++;
            $display("FAIL reset_et0: ov=%b busy=%b po=%h required 0 0 00000", out_valid0, busy0, po0);
        end
        rst_n = 1'b1;
        cycle();
        checks++;
        if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: et1=%b et0=%b required 1 1", in_ready1, in_ready0);
        end
    endtask

    task automatic test_max();
        int lat, bn; logic [19:0] po_v;
        sel = 1'b1;
        out_ready = 1'b1;
        run_op(8'hFF, 8'hFF, lat, bn, po_v);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL max_latency: got %0d required 4", lat); end
        checks++;
        if (po_v !== 20'h0FE01) begin errors++; $display("FAIL max_po: got %h required 0fe01", po_v); end
        checks++;
        if (bn != 4) begin errors++; $display("FAIL max_busy: got %0d cycles required 4", bn); end
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_early_term();
        int lat, bn; logic [19:0] po_v;
        sel = 1'b1;
        run_op(8'h03, 8'hC8, lat, bn, po_v);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL et_short_latency: got %0d required 1", lat); end
        checks++;
        if (po_v !== 20'h00258) begin errors++; $display("FAIL et_short_po: got %h required 00258", po_v); end
        deliver();
        run_op(8'h40, 8'h05, lat, bn, po_v);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL et_top_latency: got %0d required 4", lat); end
        checks++;
        if (po_v !== 20'h00140) begin errors++; $display("FAIL et_top_po: got %h required 00140", po_v); end
        deliver();
    endtask

    task automatic test_zero();
        int lat, bn; logic [19:0] po_v;
        sel = 1'b1;
        run_op(8'h00, 8'h7F, lat, bn, po_v);
        checks++;
        if (lat != 1 || po_v !== 20'd0 || bn != 0) begin
            errors++;
            $display("FAIL zero_a: lat=%0d po=%h busy=%0d required 1 00000 0", lat, po_v, bn);
        end
        deliver();
        run_op(8'h5A, 8'h00, lat, bn, po_v);
        checks++;
        if (lat != 1 || po_v !== 20'd0 || bn != 0) begin
            errors++;
            $display("FAIL zero_b: lat=%0d po=%h busy=%0d required 1 00000 0", lat, po_v, bn);
        end
        deliver();
    endtask

    task automatic test_backpressure();
        int lat, bn; logic [19:0] po_v;
        sel = 1'b1;
        out_ready = 1'b0;
        run_op(8'h12, 8'h34, lat, bn, po_v);
        checks++;
        if (lat != 3 || po_v !== 20'h003A8) begin
            errors++;
            $display("FAIL bp_first: lat=%0d po=%h required 3 003a8", lat, po_v);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;   // must be ignored while a result is pending
            cycle();
            checks++;
            if (out_valid_m !== 1'b1 || po_m !== 20'h003A8 || in_ready_m !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cyc=%0d ov=%b po=%h in_ready=%b required 1 003a8 0",
                         i, out_valid_m, po_m, in_ready_m);
            end
        end
        in_valid = 1'b0;
        deliver();
        checks++;
        if (out_valid_m !== 1'b0 || in_ready_m !== 1'b1 || po_m !== 20'h003A8) begin
            errors++;
            $display("FAIL bp_release: ov=%b in_ready=%b po=%h required 0 1 003a8",
                     out_valid_m, in_ready_m, po_m);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bn; logic [19:0] po_v;
        sel = 1'b1;
        A = 8'hFF; B = 8'h02; in_valid = 1'b1;
        cycle();                 // accept edge
        in_valid = 1'b0;
        @(posedge clk);          // first CALC edge
        @(posedge clk);          // second CALC edge
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_m !== 1'b0 || po_m !== 20'd0 || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ov=%b po=%h busy=%b required 0 00000 0", out_valid_m, po_m, busy_m);
        end
        cycle();
        rst_n = 1'b1;
        cycle();
        checks++;
        if (in_ready_m !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: in_ready=%b required 1", in_ready_m);
        end
        run_op(8'h02, 8'h03, lat, bn, po_v);
        checks++;
        if (po_v !== 20'h00006 || lat != 1) begin
            errors++;
            $display("FAIL reset_mid_after: po=%h lat=%0d required 00006 1", po_v, lat);
        end
        deliver();
    endtask

    task automatic test_random(input bit et, input int n_ops);
        logic [7:0]  a, b;
        logic [15:0] q[$];
        logic [15:0] exp16;
        logic [19:0] held;
        int lat, exp_lat, cyc, delivered;
        bit take;
        sel = et;
        delivered = 0;
        in_valid = 1'b0; out_ready = 1'b0;
        cycle();
        for (int i = 0; i < n_ops; i++) begin
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'($urandom_range(0, 1));
                cycle();
            end
            a = 8'($urandom); b = 8'($urandom);
            case ($urandom_range(0, 7))
                0:       a = 8'd0;
                1:       b = 8'd0;
                2:       a = a & 8'h0F;
                3:       a = a & 8'h03;
                default: ;
            endcase
            checks++;
            if (in_ready_m !== 1'b1) begin
                errors++;
                $display("FAIL rnd_ready: et=%0d op=%0d in_ready=%b required 1", et, i, in_ready_m);
            end
            A = a; B = b; in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            A = 8'($urandom); B = 8'($urandom);
            exp16 = 16'(a) * 16'(b);
            q.push_back(exp16);
            exp_lat = ref_latency(a, b, et);
            lat = 0;
            while (!out_valid_m && lat < 40) begin
                out_ready = 1'($urandom_range(0, 1));
                cycle();
                lat++;
            end
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL rnd_latency: et=%0d a=%h b=%h got %0d required %0d", et, a, b, lat, exp_lat);
            end
            if (!out_valid_m) begin
                errors++;
                $display("FAIL rnd_timeout: et=%0d a=%h b=%h no out_valid", et, a, b);
                return;
            end
            held = po_m;
            take = 1'b0;
            cyc = 0;
            while (!take && cyc < 30) begin
                take = ($urandom_range(0, 2) != 0);
                out_ready = take;
                cycle();
                cyc++;
                if (!take) begin
                    checks++;
                    if (out_valid_m !== 1'b1 || po_m !== held) begin
                        errors++;
                        $display("FAIL rnd_hold: et=%0d ov=%b po=%h required 1 %h", et, out_valid_m, po_m, held);
                    end
                end
            end
            out_ready = 1'b0;
            exp16 = q.pop_front();
            delivered++;
            checks++;
            if (held !== {4'd0, exp16}) begin
                errors++;
                $display("FAIL rnd_product: et=%0d a=%h b=%h got %h required %h", et, a, b, held, {4'd0, exp16});
            end
            checks++;
            if (out_valid_m !== 1'b0 || po_m !== held) begin
                errors++;
                $display("FAIL rnd_after_deliver: et=%0d ov=%b po=%h required 0 %h", et, out_valid_m, po_m, held);
            end
        end
        checks++;
        if (delivered != n_ops || q.size() != 0) begin
            errors++;
            $display("FAIL rnd_count: et=%0d delivered=%0d pending=%0d required %0d 0", et, delivered, q.size(), n_ops);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_max();
        test_early_term();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_random(1'b1, 2000);
        test_random(1'b0, 2000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
